lsnn_neuron_array: RTL and testbench

//  Parametrised, time-multiplexed array of adaptive leaky integrate-and-fire (LSNN) neurons.

---
 rtl/lsnn_neuron_array.sv | 161 ++++++++++++++++
 tb/tb_lsnn_neuron_array.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/lsnn_neuron_array.sv
// Time-multiplexed array of adaptive leaky integrate-and-fire neurons.
// One shared datapath updates one neuron per clock; a spike vector is published per timestep.
module lsnn_neuron_array #(
  parameter int N_NEURONS   = 4,
  parameter int VW          = 12,
  parameter int AW          = 8,
  parameter int THETA       = 100,
  parameter int LEAK_SHIFT  = 3,
  parameter int BETA        = 20,
  parameter int ADAPT_SHIFT = 4,
  parameter int REFR        = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    step_valid,
  output logic                    step_ready,
  input  logic [N_NEURONS*VW-1:0] i_in,
  output logic [N_NEURONS-1:0]    spike_out,
  output logic                    spike_valid,
  output logic                    busy
);

  localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int RW = (REFR > 0) ? $clog2(REFR + 1) : 1;
  localparam int EW = VW + 2;
  localparam logic signed [EW-1:0] V_MAX_E   = EW'((2 ** (VW - 1)) - 1);
  localparam logic signed [EW-1:0] V_MIN_E   = EW'(-(2 ** (VW - 1)));
  localparam logic signed [EW-1:0] THETA_E   = EW'(THETA);

  typedef enum logic [1:0] {IDLE = 2'd0, UPDATE = 2'd1, DONE = 2'd2} state_t;

  state_t state_r, state_next_s;

  logic signed [VW-1:0]    v_r    [N_NEURONS];
  logic [AW-1:0]           a_r    [N_NEURONS];
  logic [RW-1:0]           refr_r [N_NEURONS];
  logic [N_NEURONS*VW-1:0] i_lat_r;
  logic [IW-1:0]           idx_r;
  logic [N_NEURONS-1:0]    spk_col_r;
  logic [N_NEURONS-1:0]    spike_out_r;

  logic signed [VW-1:0] v_cur_s, i_cur_s, vn_s, v_new_s;
  logic [AW-1:0]        a_cur_s, a_dec_s, a_sat_s, a_new_s;
  logic [AW:0]          a_inc_s;
  logic [RW-1:0]        refr_cur_s, refr_new_s;
  logic signed [EW-1:0] v_ext_s, vsum_s, thr_s;
  logic                 spike_s, last_s;
  logic [N_NEURONS-1:0] spk_next_s;

  // Clamp a widened value into the signed VW-bit range instead of wrapping.
  function automatic logic signed [VW-1:0] sat_vw(input logic signed [EW-1:0] x);
    if (x > V_MAX_E) begin
      return V_MAX_E[VW-1:0];
    end else if (x < V_MIN_E) begin
      return V_MIN_E[VW-1:0];
    end else begin
      return x[VW-1:0];
    end
  endfunction

  // Step-sequencing state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Next-state logic; clear in IDLE blocks acceptance of a step.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (step_valid && !clear) state_next_s = UPDATE;
               else                      state_next_s = IDLE;
      UPDATE:  if (last_s) state_next_s = DONE;
               else        state_next_s = UPDATE;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Shared per-neuron datapath operating on the neuron selected by idx_r.
  always_comb begin
    v_cur_s    = v_r[idx_r];
    a_cur_s    = a_r[idx_r];
    refr_cur_s = refr_r[idx_r];
    i_cur_s    = i_lat_r[idx_r*VW +: VW];
    last_s     = (idx_r == IW'(N_NEURONS - 1));
    v_ext_s    = EW'(v_cur_s);
    vsum_s     = v_ext_s - (v_ext_s >>> LEAK_SHIFT) + EW'(i_cur_s);
    vn_s       = sat_vw(vsum_s);
    thr_s      = THETA_E + $signed({{(EW - AW){1'b0}}, a_cur_s});
    a_dec_s    = a_cur_s - (a_cur_s >> ADAPT_SHIFT);
    a_inc_s    = {1'b0, a_cur_s} + (AW + 1)'(BETA);
    a_sat_s    = a_inc_s[AW] ? {AW{1'b1}} : a_inc_s[AW-1:0];
    spike_s    = 1'b0;
    v_new_s    = vn_s;
    a_new_s    = a_dec_s;
    refr_new_s = refr_cur_s;
    if (refr_cur_s != RW'(0)) begin
      v_new_s    = '0;
      refr_new_s = refr_cur_s - RW'(1);
    end else if (EW'(vn_s) >= thr_s) begin
      spike_s    = 1'b1;
      v_new_s    = '0;
      a_new_s    = a_sat_s;
      refr_new_s = RW'(REFR);
    end else begin
      v_new_s    = vn_s;
    end
    spk_next_s         = spk_col_r;
    spk_next_s[idx_r]  = spike_s;
  end

  // Neuron state, input latch, index and spike collection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        v_r[k]    <= '0;
        a_r[k]    <= '0;
        refr_r[k] <= '0;
      end
      i_lat_r     <= '0;
      idx_r       <= '0;
      spk_col_r   <= '0;
      spike_out_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (clear) begin
            for (int k = 0; k < N_NEURONS; k++) begin
              v_r[k]    <= '0;
              a_r[k]    <= '0;
              refr_r[k] <= '0;
            end
          end else if (step_valid) begin
            i_lat_r   <= i_in;
            idx_r     <= '0;
            spk_col_r <= '0;
          end
        end
        UPDATE: begin
          v_r[idx_r]    <= v_new_s;
          a_r[idx_r]    <= a_new_s;
          refr_r[idx_r] <= refr_new_s;
          spk_col_r     <= spk_next_s;
          idx_r         <= idx_r + IW'(1);
          // Publish on the last update so spike_out is fresh in the DONE cycle.
          if (last_s) spike_out_r <= spk_next_s;
        end
        default: begin
        end
      endcase
    end
  end

  assign spike_out   = spike_out_r;
  assign spike_valid = (state_r == DONE);
  assign busy        = (state_r != IDLE);
  assign step_ready  = (state_r == IDLE) && !clear;

endmodule

// File: tb/tb_lsnn_neuron_array.sv
// Directed self-checking bench for lsnn_neuron_array with hand-computed neuron trajectories.
module tb_lsnn_neuron_array;

  logic        clk = 1'b0;
  logic        rst, clear, step_valid;
  logic        step_ready, spike_valid, busy;
  logic [47:0] i_in;
  logic [3:0]  spike_out;
  logic [3:0]  spk;
  int          n_checks = 0;
  int          n_fail   = 0;

  lsnn_neuron_array dut (
    .clk(clk), .rst(rst), .clear(clear), .step_valid(step_valid), .step_ready(step_ready),
    .i_in(i_in), .spike_out(spike_out), .spike_valid(spike_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [47:0] pack(input int i0, input int i1, input int i2, input int i3);
    return {12'(i3), 12'(i2), 12'(i1), 12'(i0)};
  endfunction

  // Issue one step, wait (bounded) for spike_valid, return spike_out seen in the DONE cycle.
  task automatic run_step(input logic [47:0] cur, output logic [3:0] s);
    int cnt;
    @(negedge clk);
    i_in = cur;
    step_valid = 1'b1;
    @(negedge clk);
    step_valid = 1'b0;
    cnt = 0;
    while (!spike_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("step_latency", 32'(cnt), 32'd4);
    s = spike_out;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; step_valid = 1'b0; i_in = '0;
    repeat (2) @(negedge clk);
    check("rst_spike_out", 32'(spike_out), 32'd0);
    check("rst_spike_valid", 32'(spike_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_step_ready", 32'(step_ready), 32'd1);
    run_step(pack(0, 0, 0, 0), spk);
    check("zero_step_spk", 32'(spk), 32'd0);

    // Neuron 0 integrates 50 per step: 50, 94, 133 -> spike
    run_step(pack(50, 0, 0, 0), spk);
    check("s1_spk", 32'(spk), 32'd0);
    check("s1_v0", 32'(dut.v_r[0]), 32'd50);
    run_step(pack(50, 0, 0, 0), spk);
    check("s2_v0", 32'(dut.v_r[0]), 32'd94);
    run_step(pack(50, 0, 0, 0), spk);
    check("s3_spk", 32'(spk), 32'd1);
    check("s3_v0", 32'(dut.v_r[0]), 32'd0);
    check("s3_a0", 32'(dut.a_r[0]), 32'd20);
    // Refractory steps then resumed integration
    run_step(pack(50, 0, 0, 0), spk);
    check("s4_spk", 32'(spk), 32'd0);
    check("s4_v0", 32'(dut.v_r[0]), 32'd0);
    check("s4_a0", 32'(dut.a_r[0]), 32'd19);
    run_step(pack(50, 0, 0, 0), spk);
    check("s5_v0", 32'(dut.v_r[0]), 32'd0);
    check("s5_a0", 32'(dut.a_r[0]), 32'd18);
    run_step(pack(50, 0, 0, 0), spk);
    check("s6_spk", 32'(spk), 32'd0);
    check("s6_v0", 32'(dut.v_r[0]), 32'd50);
    check("s6_a0", 32'(dut.a_r[0]), 32'd17);

    // Negative saturation on neuron 1
    for (int s = 0; s < 3; s++) begin
      run_step(pack(0, -2048, 0, 0), spk);
      check("sat_v1", 32'(dut.v_r[1]), 32'hFFFF_F800);
      check("sat_spk1", 32'(spk[1]), 32'd0);
    end

    // Back-to-back handshake with step_valid held high
    @(negedge clk);
    i_in = pack(0, 0, 0, 0);
    step_valid = 1'b1;
    check("hs_ready_c0", 32'(step_ready), 32'd1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("hs_ready_busy", 32'(step_ready), 32'd0);
      check("hs_spike_valid", 32'(spike_valid), (c == 5) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("hs_ready_c6", 32'(step_ready), 32'd1);
    @(negedge clk);
    step_valid = 1'b0;
    check("hs_reaccept_busy", 32'(busy), 32'd1);
    repeat (6) @(negedge clk);

    // Reset in the middle of a step
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_step(pack(200, 0, 0, 0), spk);
    check("pre_rst_spk", 32'(spk), 32'd1);
    @(negedge clk);
    i_in = pack(50, 0, 0, 0);
    step_valid = 1'b1;
    @(negedge clk);
    step_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_spike_out", 32'(spike_out), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_spike_valid", 32'(spike_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_step(pack(90, 0, 0, 0), spk);
    check("fresh_spk", 32'(spk), 32'd0);
    check("fresh_v0", 32'(dut.v_r[0]), 32'd90);
    check("fresh_a0", 32'(dut.a_r[0]), 32'd0);

    // clear together with step_valid: clear wins
    @(negedge clk);
    clear = 1'b1;
    step_valid = 1'b1;
    #1;
    check("clr_ready", 32'(step_ready), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    step_valid = 1'b0;
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_v0", 32'(dut.v_r[0]), 32'd0);
    check("clr_spike_out", 32'(spike_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
